uart_rx_arb: RTL and testbench
==============================

UART_RX_ARB -- requirements
Module: uart_rx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of every stream.
REQ-002 SHALL have parameter CHANNELS, default 4: receiver count, legal range 2..8.
REQ-003 SHALL have parameter ID_WIDTH, default 2: m_axis_tid width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 s_axis_tdata  in  CHANNELS*DATA_WIDTH  per-receiver bytes, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_axis_tvalid  in  CHANNELS  per-receiver byte valid.
REQ-008 s_axis_tready  out  CHANNELS  per-receiver accept.
REQ-009 frame_error_in  in  CHANNELS  single-cycle frame-error pulses from receivers.
REQ-010 overrun_error_in  in  CHANNELS  single-cycle overrun pulses from receivers.
REQ-011 m_axis_tdata  out  DATA_WIDTH  merged byte.
REQ-012 m_axis_tid  out  ID_WIDTH  source channel of m_axis_tdata.
REQ-013 m_axis_tvalid  out  1  merged byte valid.
REQ-014 m_axis_tready  in  1  downstream accept.
REQ-015 err_clear  in  1  synchronous clear of all error counters.
REQ-016 err_count  out  CHANNELS*8  per-channel saturating error counters, channel i at [i*8 +: 8].
REQ-017 busy  out  1  high while m_axis_tvalid is high or any s_axis_tvalid is high.

Function
REQ-018 Output stage SHALL be one register holding {tdata, tid}; it is "free" when m_axis_tvalid=0 or m_axis_tready=1.
REQ-019 When free, the arbiter SHALL assert exactly one s_axis_tready bit, that of the granted channel; all other bits 0. When not free, all s_axis_tready bits SHALL be 0.
REQ-020 Grant SHALL be round-robin: search starts at channel (last_grant+1) mod CHANNELS, first channel with s_axis_tvalid=1 wins; s_axis_tready is combinational from s_axis_tvalid, last_grant and output-free status.
REQ-021 last_grant SHALL update only on an accepted transfer (s_axis_tvalid[i] & s_axis_tready[i]); it resets to CHANNELS-1 so channel 0 has first priority.
REQ-022 On acceptance, m_axis_tdata/m_axis_tid SHALL load on the same edge; m_axis_tvalid asserts the next cycle (latency 1 cycle).
REQ-023 m_axis_tvalid SHALL clear on m_axis_tready=1 unless a new byte is accepted on the same edge; full throughput of 1 byte/cycle when m_axis_tready stays high.
REQ-024 m_axis_tdata/m_axis_tid SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 With no s_axis_tvalid set, no grant, last_grant unchanged.
REQ-026 err_count[i] SHALL increment by 1 in any cycle where frame_error_in[i] or overrun_error_in[i] is 1 (both in one cycle count once).
REQ-027 err_count[i] SHALL saturate at 255; further events leave it at 255.
REQ-028 err_clear=1 SHALL zero all counters and SHALL win over a simultaneous increment.
REQ-029 Error counting SHALL be independent of arbitration and backpressure.

Reset
REQ-030 On rst assertion, asynchronously: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, all err_count=0, last_grant=CHANNELS-1.
REQ-031 During rst, s_axis_tready SHALL be all 0 and busy SHALL reflect only s_axis_tvalid.
REQ-032 Reset mid-transfer SHALL discard the held byte; no byte SHALL be emitted after reset release until a new acceptance.

Structure
REQ-033 Shared package uart_pkg SHALL hold DATA_WIDTH default, ERR_CNT_WIDTH=8 and the CHANNELS legal-range constants.
REQ-034 Round-robin grant logic SHALL be one sub-module uart_rr_arbiter (inputs: request vector, last_grant, enable; output: one-hot grant plus encoded index).

Verification
REQ-035 Channels 0..3 all valid with bytes 0xA0..0xA3 held, m_axis_tready=1 -> output tid order 0,1,2,3,0, one byte per cycle, first m_axis_tvalid 1 cycle after first acceptance.
REQ-036 Only channel 2 valid with 0x5A, m_axis_tready=0 for 5 cycles -> m_axis_tvalid=1, tdata=0x5A, tid=2 stable all 5 cycles, all s_axis_tready=0 until release.
REQ-037 Grant to channel 1, then channels 1 and 3 valid -> channel 3 granted next (fairness), then channel 1.
REQ-038 300 frame_error_in[0] pulses -> err_count[0]=255; frame_error_in[1] and overrun_error_in[1] same cycle -> err_count[1]=1; err_clear with coincident pulse -> counter 0.
REQ-039 rst asserted while m_axis_tvalid=1 holding 0x33 -> m_axis_tvalid falls immediately (asynchronous), after release channel 0 has first priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-side arbitration slice: default byte
// width, error-counter width and the supported receiver-count range.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ERR_CNT_WIDTH  = 8;
    localparam int CHANNELS_MIN   = 2;
    localparam int CHANNELS_MAX   = 8;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin grant: the search starts one past the last winner,
// and the first requesting channel gets a one-hot grant plus its index.
module uart_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [ID_WIDTH-1:0] last_grant,
    input  logic                enable,
    output logic [CHANNELS-1:0] grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic                found;
    logic [ID_WIDTH-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Offset CHANNELS wraps to last_grant itself, so it is checked last.
        for (int off = 1; off <= CHANNELS; off++) begin
            cand = ID_WIDTH'((int'(last_grant) + off) % CHANNELS);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_rx_arb.sv
// Merges several UART receiver byte streams into one tagged stream through a
// single output register, and keeps a saturating error counter per receiver.
module uart_rx_arb
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CHANNELS   = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [CHANNELS-1:0]               s_axis_tvalid,
    output logic [CHANNELS-1:0]               s_axis_tready,
    input  logic [CHANNELS-1:0]               frame_error_in,
    input  logic [CHANNELS-1:0]               overrun_error_in,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [ID_WIDTH-1:0]               m_axis_tid,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic                              err_clear,
    output logic [CHANNELS*ERR_CNT_WIDTH-1:0] err_count,
    output logic                              busy
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("uart_rx_arb: CHANNELS out of supported range");
    end
    if (ID_WIDTH != $clog2(CHANNELS)) begin : g_bad_id_width
        $error("uart_rx_arb: ID_WIDTH must equal clog2(CHANNELS)");
    end

    logic                  out_free;
    logic                  arb_enable;
    logic                  accept;
    logic [CHANNELS-1:0]   grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   last_grant_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic [ID_WIDTH-1:0]   tid_reg;
    logic                  tvalid_reg;
    logic [DATA_WIDTH-1:0] chan_data [CHANNELS];

    assign out_free   = !tvalid_reg || m_axis_tready;
    // Holding the arbiter off during reset keeps every tready low.
    assign arb_enable = out_free && !rst;

    uart_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign s_axis_tready = grant;
    assign accept        = |grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_reg      <= '0;
            tid_reg        <= '0;
            tvalid_reg     <= 1'b0;
            last_grant_reg <= ID_WIDTH'(CHANNELS - 1);
        end else if (accept) begin
            tdata_reg      <= chan_data[grant_idx];
            tid_reg        <= grant_idx;
            tvalid_reg     <= 1'b1;
            last_grant_reg <= grant_idx;
        end else if (m_axis_tready) begin
            tvalid_reg     <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tid    = tid_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign busy          = tvalid_reg || (|s_axis_tvalid);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [ERR_CNT_WIDTH-1:0] cnt_reg;

            assign chan_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];

            // Clear beats a coincident event; a frame and overrun error together count once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (err_clear) begin
                    cnt_reg <= '0;
                end else if ((frame_error_in[gi] || overrun_error_in[gi]) &&
                             cnt_reg != ERR_CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign err_count[gi*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_uart_rx_arb.sv
// Self-checking bench for uart_rx_arb: a cycle-level reference model is compared
// against the DUT every cycle, alongside hand-computed directed expectations.
module tb_uart_rx_arb;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*DW-1:0]  s_axis_tdata;
    logic [CH-1:0]     s_axis_tvalid;
    logic [CH-1:0]     s_axis_tready;
    logic [CH-1:0]     frame_error_in;
    logic [CH-1:0]     overrun_error_in;
    logic [DW-1:0]     m_axis_tdata;
    logic [IW-1:0]     m_axis_tid;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              err_clear;
    logic [CH*8-1:0]   err_count;
    logic              busy;

    uart_rx_arb #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .ID_WIDTH   (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .frame_error_in   (frame_error_in),
        .overrun_error_in (overrun_error_in),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tid       (m_axis_tid),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .err_clear        (err_clear),
        .err_count        (err_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: output register contents, last winner, error tallies.
    bit mv     = 1'b0;
    int md     = 0;
    int mt     = 0;
    int lg     = CH - 1;
    int cnt [CH];

    function automatic logic [CH-1:0] exp_ready();
        logic [CH-1:0] r;
        int c;
        r = '0;
        if (rst !== 1'b0) return r;
        if (mv && !m_axis_tready) return r;
        for (int k = 1; k <= CH; k++) begin
            c = (lg + k) % CH;
            if (s_axis_tvalid[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [CH-1:0] r;
        int g;
        if (rst) begin
            mv = 1'b0; md = 0; mt = 0; lg = CH - 1;
            for (int c = 0; c < CH; c++) cnt[c] = 0;
        end else begin
            r = exp_ready();
            g = -1;
            for (int c = 0; c < CH; c++) if (r[c]) g = c;
            if (g >= 0) begin
                mv = 1'b1; md = int'(s_axis_tdata[g*DW +: DW]); mt = g; lg = g;
            end else if (m_axis_tready) begin
                mv = 1'b0;
            end
            for (int c = 0; c < CH; c++) begin
                if (err_clear) cnt[c] = 0;
                else if (frame_error_in[c] || overrun_error_in[c])
                    cnt[c] = (cnt[c] < 255) ? cnt[c] + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_tvalid", 32'(m_axis_tvalid), 32'(mv));
            if (mv) begin
                check("m_tdata", 32'(m_axis_tdata), md);
                check("m_tid", 32'(m_axis_tid), mt);
            end
            check("s_tready", 32'(s_axis_tready), 32'(exp_ready()));
            check("busy", 32'(busy), 32'(mv | (|s_axis_tvalid)));
            for (int c = 0; c < CH; c++)
                check($sformatf("err_count[%0d]", c), 32'(err_count[c*8 +: 8]), cnt[c]);
            if (m_axis_tvalid && m_axis_tready)
                $display("xfer: tid=%0d data=%02h t=%0t", m_axis_tid, m_axis_tdata, $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = '0;
        frame_error_in = '0; overrun_error_in = '0;
        m_axis_tready = 1'b0; err_clear = 1'b0;
        repeat (2) step();

        // Reset state and behaviour while reset is held.
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tid", 32'(m_axis_tid), 32'd0);
        check("rst_err", err_count, 32'd0);
        s_axis_tvalid = 4'b1111;
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        s_axis_tvalid = '0;
        rst = 1'b0;
        started = 1'b1;
        step();

        // All four channels valid, sink always ready.
        s_axis_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        s_axis_tvalid = 4'b1111;
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("rr_first_ready", 32'(s_axis_tready), 32'b0001);
        check("rr_latency", 32'(m_axis_tvalid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("rr_tid", 32'(m_axis_tid), order[k]);
            check("rr_tdata", 32'(m_axis_tdata), 32'hA0 + order[k]);
        end
        step();
        s_axis_tvalid = '0;
        repeat (3) step();

        // Backpressure on a single channel.
        s_axis_tdata  = 32'h005A_0000;
        s_axis_tvalid = 4'b0100;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("bp_first_ready", 32'(s_axis_tready), 32'b0100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("bp_tdata", 32'(m_axis_tdata), 32'h5A);
            check("bp_tid", 32'(m_axis_tid), 32'd2);
            check("bp_tready", 32'(s_axis_tready), 32'd0);
        end
        step();
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(s_axis_tready), 32'b0100);
        step();
        s_axis_tvalid = '0;
        repeat (2) step();

        // Fairness: channel 1 wins, then 3 beats 1, then 1 again.
        s_axis_tdata  = {8'h33, 8'h00, 8'h11, 8'h00};
        s_axis_tvalid = 4'b0010;
        @(negedge clk);
        check("fair_ready_a", 32'(s_axis_tready), 32'b0010);
        step();
        s_axis_tvalid = 4'b1010;
        @(negedge clk);
        check("fair_ready_b", 32'(s_axis_tready), 32'b1000);
        check("fair_tid_a", 32'(m_axis_tid), 32'd1);
        check("fair_tdata_a", 32'(m_axis_tdata), 32'h11);
        step();
        @(negedge clk);
        check("fair_ready_c", 32'(s_axis_tready), 32'b0010);
        check("fair_tid_b", 32'(m_axis_tid), 32'd3);
        check("fair_tdata_b", 32'(m_axis_tdata), 32'h33);
        step();
        s_axis_tvalid = '0;
        repeat (2) step();

        // Error counters, exercised under output backpressure.
        s_axis_tdata  = 32'h0000_0077;
        s_axis_tvalid = 4'b0001;
        m_axis_tready = 1'b0;
        frame_error_in = 4'b0001;
        repeat (300) step();
        frame_error_in = '0;
        @(negedge clk);
        check("err_sat", 32'(err_count[7:0]), 32'd255);
        check("err_other", 32'(err_count[15:8]), 32'd0);
        step();
        frame_error_in = 4'b0010; overrun_error_in = 4'b0010;
        step();
        frame_error_in = '0; overrun_error_in = '0;
        @(negedge clk);
        check("err_both_once", 32'(err_count[15:8]), 32'd1);
        step();
        err_clear = 1'b1; frame_error_in = 4'b0001; overrun_error_in = 4'b0010;
        step();
        err_clear = 1'b0; frame_error_in = '0; overrun_error_in = '0;
        @(negedge clk);
        check("err_clear0", 32'(err_count[7:0]), 32'd0);
        check("err_clear1", 32'(err_count[15:8]), 32'd0);
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        repeat (3) step();

        // Reset while a byte is held.
        s_axis_tdata  = 32'h0000_3300;
        s_axis_tvalid = 4'b0010;
        m_axis_tready = 1'b0;
        step();
        s_axis_tvalid = '0;
        @(negedge clk);
        check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("hold_tdata", 32'(m_axis_tdata), 32'h33);
        #2;
        rst = 1'b1;
        #1;
        check("async_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("async_tdata", 32'(m_axis_tdata), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        s_axis_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        s_axis_tvalid = 4'b1111;
        @(negedge clk);
        check("inrst_ready", 32'(s_axis_tready), 32'd0);
        check("inrst_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("post_rst_ready", 32'(s_axis_tready), 32'b0001);
        step();
        @(negedge clk);
        check("post_rst_tid", 32'(m_axis_tid), 32'd0);
        check("post_rst_tdata", 32'(m_axis_tdata), 32'hA0);
        step();
        s_axis_tvalid = '0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
